// File: rtl/param_deserializer.sv
// Serial-to-parallel converter: collects DATA_WIDTH strobed bits (LSB- or MSB-first)
// and publishes each word with a one-cycle valid pulse. Optional parity output: DESER_PARITY_EN.
module param_deserializer #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  clear,
    input  logic                  deser_en,
    input  logic                  bit_strobe,
    input  logic                  sampled_bit,
    input  logic                  msb_first,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  p_valid,
    output logic [CNT_WIDTH-1:0]  bit_cnt,
`ifdef DESER_PARITY_EN
    output logic                  busy,
    output logic                  par_out
`else
    output logic                  busy
`endif
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    order_q, order_d;
    logic                    load_q, load_d;
    logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
    logic                    p_valid_q, p_valid_d;

    logic accept_s;
    logic last_s;
    logic order_s;

    assign accept_s = deser_en & bit_strobe & ~clear;
    assign last_s   = accept_s & (cnt_q == LAST_CNT);
    // The first bit of a frame uses the live order input; later bits use the latched one.
    assign order_s  = (cnt_q == CNT_ZERO) ? msb_first : order_q;

    // Next-state logic for the frame FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = COLLECT;
                end else begin
                    state_d = IDLE;
                end
            end
            COLLECT: begin
                if (clear || last_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = COLLECT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: shift register, bit counter, order latch and output staging.
    always_comb begin
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        order_d   = order_q;
        load_d    = 1'b0;
        p_valid_d = load_q;
        if (load_q) begin
            p_data_d = shreg_q;
        end else begin
            p_data_d = p_data_q;
        end
        if (clear) begin
            shreg_d = {DATA_WIDTH{1'b0}};
            cnt_d   = CNT_ZERO;
            order_d = 1'b0;
        end else if (accept_s) begin
            order_d = order_s;
            if (order_s) begin
                shreg_d = {shreg_q[DATA_WIDTH-2:0], sampled_bit};
            end else begin
                shreg_d = {sampled_bit, shreg_q[DATA_WIDTH-1:1]};
            end
            if (last_s) begin
                cnt_d  = CNT_ZERO;
                load_d = 1'b1;
            end else begin
                cnt_d  = cnt_q + CNT_ONE;
            end
        end else begin
            shreg_d = shreg_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            shreg_q   <= {DATA_WIDTH{1'b0}};
            cnt_q     <= CNT_ZERO;
            order_q   <= 1'b0;
            load_q    <= 1'b0;
            p_data_q  <= {DATA_WIDTH{1'b0}};
            p_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            order_q   <= order_d;
            load_q    <= load_d;
            p_data_q  <= p_data_d;
            p_valid_q <= p_valid_d;
        end
    end

    assign P_DATA  = p_data_q;
    assign p_valid = p_valid_q;
    assign bit_cnt = cnt_q;
    assign busy    = (state_q == COLLECT);

`ifdef DESER_PARITY_EN
    function automatic logic parity_step(input logic acc, input logic b);
        return acc ^ b;
    endfunction

    logic par_run_q, par_run_d;
    logic par_hold_q, par_hold_d;
    logic par_out_q, par_out_d;

    // Running XOR; the finished parity is parked until the load edge publishes it.
    always_comb begin
        par_run_d  = par_run_q;
        par_hold_d = par_hold_q;
        if (clear) begin
            par_run_d = 1'b0;
        end else if (last_s) begin
            par_run_d  = 1'b0;
            par_hold_d = parity_step(par_run_q, sampled_bit);
        end else if (accept_s) begin
            par_run_d = parity_step(par_run_q, sampled_bit);
        end else begin
            par_run_d = par_run_q;
        end
        if (load_q) begin
            par_out_d = par_hold_q;
        end else begin
            par_out_d = par_out_q;
        end
    end

    // Parity registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            par_run_q  <= 1'b0;
            par_hold_q <= 1'b0;
            par_out_q  <= 1'b0;
        end else begin
            par_run_q  <= par_run_d;
            par_hold_q <= par_hold_d;
            par_out_q  <= par_out_d;
        end
    end

    assign par_out = par_out_q;
`endif

endmodule

// File: tb/tb_param_deserializer.sv
// Scoreboard bench for param_deserializer: a W=8 and a W=12 instance share the serial inputs
// and have independent enables; words are queued when sent and compared when p_valid pulses.
module tb_param_deserializer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        clear = 1'b0;
    logic        en8 = 1'b0;
    logic        en12 = 1'b0;
    logic        bit_strobe = 1'b0;
    logic        sampled_bit = 1'b0;
    logic        msb_first = 1'b0;

    logic [7:0]  P_DATA8;
    logic        p_valid8;
    logic [3:0]  bit_cnt8;
    logic        busy8;
    logic [11:0] P_DATA12;
    logic        p_valid12;
    logic [3:0]  bit_cnt12;
    logic        busy12;
`ifdef DESER_PARITY_EN
    logic        par8;
    logic        par12;
`endif

    int checks = 0;
    int errors = 0;
    logic [32:0] q8[$];
    logic [32:0] q12[$];
    logic [32:0] e8;
    logic [32:0] e12;

    param_deserializer #(.DATA_WIDTH(8)) dut8 (
        .CLK(CLK), .RST(RST), .clear(clear), .deser_en(en8), .bit_strobe(bit_strobe),
        .sampled_bit(sampled_bit), .msb_first(msb_first), .P_DATA(P_DATA8),
        .p_valid(p_valid8), .bit_cnt(bit_cnt8),
`ifdef DESER_PARITY_EN
        .busy(busy8), .par_out(par8)
`else
        .busy(busy8)
`endif
    );

    param_deserializer #(.DATA_WIDTH(12)) dut12 (
        .CLK(CLK), .RST(RST), .clear(clear), .deser_en(en12), .bit_strobe(bit_strobe),
        .sampled_bit(sampled_bit), .msb_first(msb_first), .P_DATA(P_DATA12),
        .p_valid(p_valid12), .bit_cnt(bit_cnt12),
`ifdef DESER_PARITY_EN
        .busy(busy12), .par_out(par12)
`else
        .busy(busy12)
`endif
    );

    always #5 CLK = ~CLK;

    // Scoreboard: every p_valid pulse must match the oldest queued word.
    always @(negedge CLK) begin
        if (p_valid8 === 1'b1) begin
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL sb8_unexpected_pulse got P_DATA=%h expected no pulse", P_DATA8);
            end else begin
                e8 = q8.pop_front();
                if (P_DATA8 !== e8[7:0]) begin
                    errors++;
                    $display("FAIL sb8_word got %h expected %h", P_DATA8, e8[7:0]);
                end
`ifdef DESER_PARITY_EN
                if (par8 !== e8[32]) begin
                    errors++;
                    $display("FAIL sb8_parity got %b expected %b", par8, e8[32]);
                end
`endif
            end
        end
        if (p_valid12 === 1'b1) begin
            checks++;
            if (q12.size() == 0) begin
                errors++;
                $display("FAIL sb12_unexpected_pulse got P_DATA=%h expected no pulse", P_DATA12);
            end else begin
                e12 = q12.pop_front();
                if (P_DATA12 !== e12[11:0]) begin
                    errors++;
                    $display("FAIL sb12_word got %h expected %h", P_DATA12, e12[11:0]);
                end
`ifdef DESER_PARITY_EN
                if (par12 !== e12[32]) begin
                    errors++;
                    $display("FAIL sb12_parity got %b expected %b", par12, e12[32]);
                end
`endif
            end
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic push8(input logic [7:0] w);
        q8.push_back({^w, 24'h000000, w});
    endtask

    task automatic push12(input logic [11:0] w);
        q12.push_back({^w, 20'h00000, w});
    endtask

    // Sends seq[0] first, one strobe per cycle.
    task automatic send_seq8(input logic [7:0] seq, input logic mf);
        msb_first = mf;
        bit_strobe = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sampled_bit = seq[i];
            tick();
        end
        bit_strobe = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if (P_DATA8 !== 8'h00 || p_valid8 !== 1'b0 || bit_cnt8 !== 4'd0 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got P_DATA=%h pv=%b cnt=%0d busy=%b expected all 0",
                     P_DATA8, p_valid8, bit_cnt8, busy8);
        end
        #2 RST = 1'b0;
        tick();
        checks++;
        if (P_DATA12 !== 12'h000 || bit_cnt12 !== 4'd0 || busy12 !== 1'b0) begin
            errors++;
            $display("FAIL reset_release12 got P_DATA=%h cnt=%0d busy=%b expected all 0",
                     P_DATA12, bit_cnt12, busy12);
        end
    endtask

    task automatic test_lsb_first;
        logic [7:0] seq;
        seq = 8'h4D;
        en8 = 1'b1;
        msb_first = 1'b0;
        push8(8'h4D);
        bit_strobe = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sampled_bit = seq[i];
            tick();
            checks++;
            if (bit_cnt8 !== 4'((i + 1) % 8) || busy8 !== (((i + 1) % 8) != 0)) begin
                errors++;
                $display("FAIL lsb_count bit %0d got cnt=%0d busy=%b expected cnt=%0d",
                         i, bit_cnt8, busy8, (i + 1) % 8);
            end
        end
        bit_strobe = 1'b0;
        checks++;
        if (p_valid8 !== 1'b0) begin
            errors++;
            $display("FAIL lsb_latency_early got p_valid=%b expected 0", p_valid8);
        end
        tick();
        checks++;
        if (p_valid8 !== 1'b1 || P_DATA8 !== 8'h4D) begin
            errors++;
            $display("FAIL lsb_word got pv=%b P_DATA=%h expected 1 4d", p_valid8, P_DATA8);
        end
        tick();
        checks++;
        if (p_valid8 !== 1'b0 || P_DATA8 !== 8'h4D) begin
            errors++;
            $display("FAIL lsb_hold got pv=%b P_DATA=%h expected 0 4d", p_valid8, P_DATA8);
        end
    endtask

    task automatic test_msb_first;
        push8(8'hB2);
        send_seq8(8'h4D, 1'b1);
        tick();
        checks++;
        if (p_valid8 !== 1'b1 || P_DATA8 !== 8'hB2) begin
            errors++;
            $display("FAIL msb_word got pv=%b P_DATA=%h expected 1 b2", p_valid8, P_DATA8);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        logic [15:0] s;
        s = 16'h3CA5;
        msb_first = 1'b0;
        push8(8'hA5);
        push8(8'h3C);
        bit_strobe = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sampled_bit = s[i];
            checks++;
            if (bit_cnt8 !== 4'(i % 8)) begin
                errors++;
                $display("FAIL b2b_count cycle %0d got %0d expected %0d", i, bit_cnt8, i % 8);
            end
            tick();
            checks++;
            if (p_valid8 !== (i == 8)) begin
                errors++;
                $display("FAIL b2b_pulse cycle %0d got %b expected %b", i, p_valid8, (i == 8));
            end
        end
        bit_strobe = 1'b0;
        tick();
        checks++;
        if (p_valid8 !== 1'b1 || P_DATA8 !== 8'h3C) begin
            errors++;
            $display("FAIL b2b_second got pv=%b P_DATA=%h expected 1 3c", p_valid8, P_DATA8);
        end
        tick();
    endtask

    task automatic test_clear;
        logic [4:0] part;
        part = 5'b10101;
        msb_first = 1'b0;
        bit_strobe = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sampled_bit = part[i];
            tick();
        end
        clear = 1'b1;
        sampled_bit = 1'b0;
        tick();
        clear = 1'b0;
        checks++;
        if (bit_cnt8 !== 4'd0 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL clear_state got cnt=%0d busy=%b expected 0 0", bit_cnt8, busy8);
        end
        push8(8'hFF);
        send_seq8(8'hFF, 1'b0);
        tick();
        tick();
        tick();
        checks++;
        if (P_DATA8 !== 8'hFF) begin
            errors++;
            $display("FAIL clear_word got %h expected ff", P_DATA8);
        end
    endtask

    task automatic test_gap_order;
        logic [11:0] w;
        w = 12'hA3C;
        en8 = 1'b0;
        en12 = 1'b1;
        msb_first = 1'b1;
        push12(12'hA3C);
        bit_strobe = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sampled_bit = w[11-i];
            tick();
        end
        en12 = 1'b0;
        msb_first = 1'b0;
        for (int g = 0; g < 3; g++) begin
            sampled_bit = g[0];
            tick();
            checks++;
            if (busy12 !== 1'b1 || bit_cnt12 !== 4'd6) begin
                errors++;
                $display("FAIL gap_hold cycle %0d got busy=%b cnt=%0d expected 1 6",
                         g, busy12, bit_cnt12);
            end
        end
        en12 = 1'b1;
        for (int i = 6; i < 12; i++) begin
            sampled_bit = w[11-i];
            tick();
        end
        bit_strobe = 1'b0;
        tick();
        checks++;
        if (p_valid12 !== 1'b1 || P_DATA12 !== 12'hA3C) begin
            errors++;
            $display("FAIL gap_word got pv=%b P_DATA=%h expected 1 a3c", p_valid12, P_DATA12);
        end
        tick();
        en12 = 1'b0;
        en8 = 1'b1;
    endtask

    task automatic test_reset_mid;
        msb_first = 1'b0;
        push8(8'h4D);
        send_seq8(8'h4D, 1'b0);
        tick();
        tick();
        checks++;
        if (P_DATA8 !== 8'h4D) begin
            errors++;
            $display("FAIL rst_prior got %h expected 4d", P_DATA8);
        end
        bit_strobe = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sampled_bit = 1'b1;
            tick();
        end
        bit_strobe = 1'b0;
        RST = 1'b1;
        #1;
        checks++;
        if (P_DATA8 !== 8'h00 || p_valid8 !== 1'b0 || bit_cnt8 !== 4'd0 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid got P_DATA=%h pv=%b cnt=%0d busy=%b expected all 0",
                     P_DATA8, p_valid8, bit_cnt8, busy8);
        end
        tick();
        #2 RST = 1'b0;
        tick();
        // Full frame then reset while its load is in flight: no pulse may appear.
        send_seq8(8'h5A, 1'b0);
        RST = 1'b1;
        tick();
        checks++;
        if (p_valid8 !== 1'b0 || P_DATA8 !== 8'h00) begin
            errors++;
            $display("FAIL rst_inflight got pv=%b P_DATA=%h expected 0 00", p_valid8, P_DATA8);
        end
        #2 RST = 1'b0;
        tick();
        push8(8'h96);
        send_seq8(8'h96, 1'b0);
        tick();
        tick();
        checks++;
        if (P_DATA8 !== 8'h96) begin
            errors++;
            $display("FAIL rst_recover got %h expected 96", P_DATA8);
        end
    endtask

    initial begin
        tick();
        tick();
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_back_to_back();
        test_clear();
        test_gap_order();
        test_reset_mid();
        tick();
        checks++;
        if (q8.size() != 0 || q12.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d/%0d pending words expected 0/0", q8.size(), q12.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_deserializer.md
# param_deserializer

Parametrised serial-to-parallel converter for the UART RX path and any other bit-serial receiver in the system. It collects `DATA_WIDTH` sampled bits, qualified by a strobe, in LSB-first or MSB-first order. It publishes each completed word on a registered parallel bus with a one-cycle valid pulse. Back-to-back frames are supported without idle cycles.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: bits per word; legal range 2..32.
- `CNT_WIDTH`, default `$clog2(DATA_WIDTH+1)`: bit-counter width; derived, not overridden.

Ports:
- `CLK`  in  1  single system clock; all logic on its rising edge.
- `RST`  in  1  asynchronous, active-high reset; clears all state immediately.
- `clear`  in  1  synchronous frame restart; discards partial word.
- `deser_en`  in  1  block enable; strobes ignored while low.
- `bit_strobe`  in  1  one-cycle qualifier: `sampled_bit` is valid this cycle.
- `sampled_bit`  in  1  serial data bit.
- `msb_first`  in  1  0 = first bit lands in bit 0; 1 = first bit lands in bit `DATA_WIDTH-1`.
- `P_DATA`  out  `DATA_WIDTH`  last completed word, registered.
- `p_valid`  out  1  one-cycle pulse when `P_DATA` updates.
- `bit_cnt`  out  `CNT_WIDTH`  bits captured in current frame, 0..`DATA_WIDTH-1`.
- `busy`  out  1  high while 1..`DATA_WIDTH-1` bits are held.

## Operation
- FSM states are IDLE and COLLECT.
  - IDLE→COLLECT on the first accepted bit.
  - COLLECT→IDLE on `clear`.
  - COLLECT→IDLE on the last bit, unless another frame's first bit arrives later; the last bit itself returns the FSM to IDLE with `bit_cnt` = 0.
- An accepted bit requires `deser_en & bit_strobe & ~clear`.
- Shift register `shreg` for an accepted bit:
  - LSB-first: `shreg <= {sampled_bit, shreg[W-1:1]}`.
  - MSB-first: `shreg <= {shreg[W-2:0], sampled_bit}`.
- Order latch: `msb_first` is latched into `order_q` when an accepted bit has `bit_cnt` = 0. Changes mid-frame are ignored until the next frame.
- `bit_cnt` increments per accepted bit. On the `DATA_WIDTH`-th bit:
  - `bit_cnt` wraps to 0.
  - A `load` flag is set.
- `load` copies the completed word into `P_DATA` on the next edge and raises `p_valid` for exactly one cycle.
- `P_DATA` holds its value until the next completed word; it is not cleared by `clear`.
- `clear` resets `shreg`, `bit_cnt`, `order_q` and the FSM to IDLE. A pending `load` from the previous edge still completes.
- `deser_en` low freezes state. A partial word is retained and resumes when `deser_en` returns high.
- `busy` = (state == COLLECT).

## Timing
- Reset values (asynchronous, while `RST` = 1):
  - `P_DATA` = 0, `p_valid` = 0, `bit_cnt` = 0, `busy` = 0.
  - `shreg` = 0, state = IDLE, `par_out` = 0 where present.
- Latency: if the last bit is accepted at edge k, `P_DATA` and `p_valid` change at edge k+1. `p_valid` deasserts at edge k+2.
- Throughput: one bit per cycle maximum, i.e. strobe tied high. A new frame's first bit may be accepted at edge k+1, concurrent with the load.
- `clear` and `bit_strobe` in the same cycle: `clear` wins, the bit is discarded, and `bit_cnt` = 0 afterwards.
- `RST` asserted mid-frame: the partial word is lost, and any in-flight `p_valid` is suppressed.
- `RST` deasserts asynchronously; the first accepted bit is the first strobe after release.

## Configuration
- `DESER_PARITY_EN` defined:
  - Adds output `par_out` (1 bit), the XOR of all `DATA_WIDTH` bits of the completed word.
  - `par_out` is computed as a running XOR and registered together with `P_DATA`, so it updates on the same edge as `p_valid`.
  - The running XOR is cleared by `clear`, by `RST`, and at frame wrap.
- `DESER_PARITY_EN` undefined:
  - The `par_out` port and the running-XOR logic are absent.
  - All other behaviour is identical.

## Test plan
- LSB-first word: W=8, `msb_first`=0, bits 1,0,1,1,0,0,1,0 strobed one per cycle → `P_DATA`=8'h4D one cycle after the 8th strobe, `p_valid` high for 1 cycle; with the macro, `par_out`=0.
- MSB-first word: W=8, `msb_first`=1, same bit sequence → `P_DATA`=8'hB2.
- Back-to-back frames: W=8, strobe held high for 16 cycles carrying 8'hA5 then 8'h3C (LSB-first) → two `p_valid` pulses 8 cycles apart with those values, and `bit_cnt` sequence 0..7,0..7.
- Clear mid-frame: W=8, 5 bits strobed, then `clear` asserted together with a strobe, then 8 new bits of 8'hFF → single `p_valid` with `P_DATA`=8'hFF, and the clear-cycle bit is not captured.
- Gap and order latch: W=12, `deser_en` dropped for 3 cycles after bit 6, and `msb_first` toggled during the gap → the word completes after 12 accepted bits using the original order, and `busy`=1 throughout the gap.
- Reset mid-frame: `RST` pulsed after 4 bits with a prior `P_DATA`=8'h4D → all outputs 0 immediately, no `p_valid`, and a subsequent full frame decodes correctly.
